data_switch_sequencer: RTL

Sequences the `data_switch` mux for the convolution core. It accepts one widened input beat of CONV_UNITS+2 words and holds it on the switch inputs. It then steps the switch select through the kernel taps (sel 0,1,2 for a 3-tap kernel, sel 0 only for 1-tap). When enabled, it inserts one bias beat (sel 3, constant 1.0) at the start of each packet. Valid/ready handshakes are used on both sides, and back-to-back input beats run with no bubbles.

---
 rtl/data_switch_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/data_switch_sequencer.sv
// Steps the data_switch select through the kernel taps for each held input beat,
// optionally leading each packet with a constant bias beat (sel 3).
module data_switch_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CONV_UNITS = 8
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   cfg_kernel3,
    input  logic                                   cfg_bias_en,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [DATA_WIDTH*(CONV_UNITS+2)-1:0]   s_data,
    input  logic                                   s_last,
    output logic [DATA_WIDTH*(CONV_UNITS+2)-1:0]   x_hold,
    output logic [1:0]                             sel,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic                                   m_last
);

    localparam int BEAT_W = DATA_WIDTH * (CONV_UNITS + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIAS = 2'd1,
        TAP  = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [1:0]          tap_q,       tap_d;
    logic [1:0]          last_tap_q,  last_tap_d;
    logic                bias_en_q,   bias_en_d;
    logic                beat_last_q, beat_last_d;
    logic                first_q,     first_d;
    logic [1:0]          sel_q,       sel_d;
    logic                m_valid_q,   m_valid_d;
    logic [BEAT_W-1:0]   x_hold_q,    x_hold_d;

    logic                accept;
    logic                load_beat;
    logic                bias_sel;
    logic                take_bias;
    logic [1:0]          last_tap_cfg;

    // The next beat may enter only when the current one is on its final tap and leaving.
    assign s_ready = (state_q == IDLE) |
                     ((state_q == TAP) & (tap_q == last_tap_q) & m_ready);
    assign accept  = s_valid & s_ready;

    // Config is live only on the first beat of a packet; later beats use the registered copy.
    assign bias_sel     = first_q ? cfg_bias_en : bias_en_q;
    assign take_bias    = first_q & bias_sel;
    assign last_tap_cfg = cfg_kernel3 ? 2'd2 : 2'd0;

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        last_tap_d  = last_tap_q;
        bias_en_d   = bias_en_q;
        beat_last_d = beat_last_q;
        first_d     = first_q;
        sel_d       = sel_q;
        m_valid_d   = m_valid_q;
        x_hold_d    = x_hold_q;
        load_beat   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_beat = 1'b1;
                end
            end
            BIAS: begin
                if (m_valid_q & m_ready) begin
                    state_d = TAP;
                    tap_d   = 2'd0;
                    sel_d   = 2'd0;
                end
            end
            TAP: begin
                if (m_valid_q & m_ready) begin
                    if (tap_q < last_tap_q) begin
                        tap_d = tap_q + 2'd1;
                        sel_d = tap_q + 2'd1;
                    end else if (accept) begin
                        load_beat = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        m_valid_d = 1'b0;
                        sel_d     = 2'd0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
                sel_d     = 2'd0;
            end
        endcase

        if (load_beat) begin
            x_hold_d    = s_data;
            beat_last_d = s_last;
            first_d     = s_last;
            m_valid_d   = 1'b1;
            if (first_q) begin
                last_tap_d = last_tap_cfg;
                bias_en_d  = cfg_bias_en;
            end
            if (take_bias) begin
                state_d = BIAS;
                sel_d   = 2'd3;
            end else begin
                state_d = TAP;
                tap_d   = 2'd0;
                sel_d   = 2'd0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            tap_q       <= 2'd0;
            last_tap_q  <= 2'd0;
            bias_en_q   <= 1'b0;
            beat_last_q <= 1'b0;
            first_q     <= 1'b1;
            sel_q       <= 2'd0;
            m_valid_q   <= 1'b0;
            x_hold_q    <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            last_tap_q  <= last_tap_d;
            bias_en_q   <= bias_en_d;
            beat_last_q <= beat_last_d;
            first_q     <= first_d;
            sel_q       <= sel_d;
            m_valid_q   <= m_valid_d;
            x_hold_q    <= x_hold_d;
        end
    end

    assign x_hold  = x_hold_q;
    assign sel     = sel_q;
    assign m_valid = m_valid_q;
    assign m_last  = (state_q == TAP) & (tap_q == last_tap_q) & beat_last_q;

endmodule
